// File: rtl/wb_pkg.sv
// Shared pipeline encodings for the write-back path: result-source select,
// load sizes, and a helper giving the bit width of a load.
package wb_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;
    localparam logic [1:0] WB_SEL_RSVD = 2'b11;

    localparam logic [1:0] LS_BYTE  = 2'b00;
    localparam logic [1:0] LS_HALF  = 2'b01;
    localparam logic [1:0] LS_WORD  = 2'b10;
    localparam logic [1:0] LS_DWORD = 2'b11;

    // A dword request on a 32-bit datapath collapses to a word access.
    function automatic logic [6:0] load_bits(input logic [1:0] size, input int xlen);
        logic [6:0] bits;
        bits = 7'd32;
        case (size)
            LS_BYTE:  bits = 7'd8;
            LS_HALF:  bits = 7'd16;
            LS_WORD:  bits = 7'd32;
            default:  bits = (xlen == 64) ? 7'd64 : 7'd32;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/wb_stage_load_extract.sv
// Load lane selection, sign/zero extension and misalignment detection.
// Purely combinational; the byte offset comes from the low address bits.
module load_extract
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  i_mem_data,
    input  logic [OFF_W-1:0] i_offset,
    input  logic [1:0]       i_size,
    input  logic             i_unsigned,
    output logic [XLEN-1:0]  o_value,
    output logic             o_misalign
);

    localparam int NBYTES = XLEN / 8;

    logic [XLEN-1:0]  w_lane [NBYTES];
    logic [XLEN-1:0]  w_shifted;
    logic [XLEN-1:0]  w_mask;
    logic [6:0]       w_bits;
    logic [OFF_W-1:0] w_align_mask;
    logic             w_sign;

    // Each lane holds the memory word pre-shifted so the addressed byte sits at bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign w_lane[gi] = i_mem_data >> (8 * gi);
        end
    endgenerate

    assign w_shifted = w_lane[i_offset];

    always_comb begin
        w_bits       = load_bits(i_size, XLEN);
        w_mask       = ~({XLEN{1'b1}} << w_bits);
        w_align_mask = OFF_W'((w_bits >> 3) - 7'd1);
        case (w_bits)
            7'd8:    w_sign = w_shifted[7];
            7'd16:   w_sign = w_shifted[15];
            7'd32:   w_sign = w_shifted[31];
            default: w_sign = w_shifted[XLEN-1];
        endcase
        // Full-width loads have an all-ones mask, so the fill term vanishes.
        o_value    = (w_shifted & w_mask) | ((w_sign && !i_unsigned) ? ~w_mask : '0);
        o_misalign = |(i_offset & w_align_mask);
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline stage: MEM->WB register with stall/flush, result select,
// load extraction, register-file write gating and a retired-instruction counter.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Valid_MEM,
    input  logic              RegWrite_MEM,
    input  logic [1:0]        WbSel_MEM,
    input  logic [1:0]        LoadSize_MEM,
    input  logic              LoadUnsigned_MEM,
    input  logic [XLEN-1:0]   ALU_result_MEM,
    input  logic [XLEN-1:0]   Mem_Data_MEM,
    input  logic [XLEN-1:0]   PC_plus4_MEM,
    input  logic [REG_AW-1:0] WriteReg_MEM,
    input  logic              Stall_WB,
    input  logic              Flush_WB,
    output logic              RegWrite_WB,
    output logic [REG_AW-1:0] WriteReg_WB,
    output logic [XLEN-1:0]   WriteReg_Data_WB,
    output logic              Valid_WB,
    output logic              Misalign_WB,
    output logic [XLEN-1:0]   Retired_WB
);

    localparam int OFF_W = $clog2(XLEN / 8);

    logic              r_valid;
    logic              r_regwrite;
    logic [1:0]        r_wbsel;
    logic [1:0]        r_loadsize;
    logic              r_loadunsigned;
    logic [XLEN-1:0]   r_alu;
    logic [XLEN-1:0]   r_mem;
    logic [XLEN-1:0]   r_pc;
    logic [REG_AW-1:0] r_writereg;
    logic [XLEN-1:0]   r_retired;

    logic [XLEN-1:0]   w_load_value;
    logic              w_load_misalign;
    logic              w_zero_dest;
    logic [XLEN-1:0]   w_data;

    // Reset and flush both leave a bubble; flush wins over stall.
    always_ff @(posedge clk) begin
        if (rst || Flush_WB) begin
            r_valid        <= 1'b0;
            r_regwrite     <= 1'b0;
            r_wbsel        <= WB_SEL_ALU;
            r_loadsize     <= LS_BYTE;
            r_loadunsigned <= 1'b0;
            r_alu          <= '0;
            r_mem          <= '0;
            r_pc           <= '0;
            r_writereg     <= '0;
        end else if (!Stall_WB) begin
            r_valid        <= Valid_MEM;
            r_regwrite     <= RegWrite_MEM;
            r_wbsel        <= WbSel_MEM;
            r_loadsize     <= LoadSize_MEM;
            r_loadunsigned <= LoadUnsigned_MEM;
            r_alu          <= ALU_result_MEM;
            r_mem          <= Mem_Data_MEM;
            r_pc           <= PC_plus4_MEM;
            r_writereg     <= WriteReg_MEM;
        end
    end

    // An instruction retires on the edge it leaves WB, so a stalled one counts once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (r_valid && !Stall_WB) begin
            r_retired <= r_retired + XLEN'(1);
        end
    end

    load_extract #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_extract (
        .i_mem_data (r_mem),
        .i_offset   (r_alu[OFF_W-1:0]),
        .i_size     (r_loadsize),
        .i_unsigned (r_loadunsigned),
        .o_value    (w_load_value),
        .o_misalign (w_load_misalign)
    );

    always_comb begin
        w_data = r_alu;
        case (r_wbsel)
            WB_SEL_LOAD: w_data = w_load_value;
            WB_SEL_LINK: w_data = r_pc;
            default:     w_data = r_alu;
        endcase
    end

    assign w_zero_dest      = (ZERO_REG != 0) && (r_writereg == '0);
    assign Misalign_WB      = r_valid && (r_wbsel == WB_SEL_LOAD) && w_load_misalign;
    assign RegWrite_WB      = r_valid && r_regwrite && !Misalign_WB && !w_zero_dest && !Stall_WB;
    assign WriteReg_WB      = r_writereg;
    assign WriteReg_Data_WB = w_data;
    assign Valid_WB         = r_valid;
    assign Retired_WB       = r_retired;

endmodule
